// File: rtl/clock_gating_pkg.sv
// Shared definitions for the neuron-memory clock-gating sequencer:
// state/phase encoding, default burst lengths and counter-width derivation.
package clock_gating_pkg;

    // Phase codes on the output are exactly the state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_CALC  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    localparam int DEF_READ_LEN  = 1024;
    localparam int DEF_CALC_LEN  = 100;
    localparam int DEF_WRITE_LEN = 1024;

    // Smallest width whose range strictly exceeds the longest phase.
    function automatic int cnt_w_for(input int read_len, input int calc_len, input int write_len);
        int longest;
        longest = read_len;
        if (calc_len > longest) longest = calc_len;
        if (write_len > longest) longest = write_len;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/clock_gating_ctrl_if.sv
// Control/status bundle between the layer controller (master) and the
// clock-gating sequencer (slave).
interface clock_gating_ctrl_if #(
    parameter int CNT_W = 11
);
    logic             start;
    logic             loop;
    logic             abort;
    logic             en_r;
    logic             en_w;
    logic [CNT_W-1:0] addr;
    logic [1:0]       phase;
    logic             busy;
    logic             done;

    modport master (
        output start, loop, abort,
        input  en_r, en_w, addr, phase, busy, done
    );

    modport slave (
        input  start, loop, abort,
        output en_r, en_w, addr, phase, busy, done
    );
endinterface

// File: rtl/clock_gating_ctrl_phase_counter.sv
// Loadable up-counter with terminal-count compare against a runtime limit;
// one instance serves every phase of the sequencer.
module phase_counter #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next,
    output logic             at_limit
);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_next = count;
        if (clr)
            count_next = '0;
        else if (inc)
            count_next = count + CNT_W'(1);
    end

    assign at_limit = (count == limit);

    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else
            count <= count_next;
    end

endmodule

// File: rtl/clock_gating_ctrl.sv
// Batch sequencer READ -> CALC -> WRITE producing registered read/write
// clock enables for the clock-gating cell.
module clock_gating_ctrl
    import clock_gating_pkg::*;
#(
    parameter int READ_LEN  = DEF_READ_LEN,
    parameter int CALC_LEN  = DEF_CALC_LEN,
    parameter int WRITE_LEN = DEF_WRITE_LEN,
    parameter int CNT_W     = cnt_w_for(READ_LEN, CALC_LEN, WRITE_LEN)
) (
    input  logic                clk,
    input  logic                reset_n,
    clock_gating_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_READ  = ST_READ;
    localparam logic [1:0] S_CALC  = ST_CALC;
    localparam logic [1:0] S_WRITE = ST_WRITE;

    localparam logic [CNT_W-1:0] READ_LIM  = CNT_W'(READ_LEN - 1);
    localparam logic [CNT_W-1:0] CALC_LIM  = CNT_W'((CALC_LEN > 0) ? CALC_LEN - 1 : 0);
    localparam logic [CNT_W-1:0] WRITE_LIM = CNT_W'(WRITE_LEN - 1);

    logic [1:0]       state, state_next;
    logic [CNT_W-1:0] limit, count, count_next;
    logic             at_limit, clr, inc;
    logic             en_r, en_w, busy, done;
    logic [CNT_W-1:0] addr;

    always_comb begin
        case (state)
            S_READ:  limit = READ_LIM;
            S_CALC:  limit = CALC_LIM;
            default: limit = WRITE_LIM;
        endcase
    end

    always_comb begin
        state_next = state;
        if (bus.abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (bus.start) state_next = S_READ;
                S_READ:  if (at_limit)  state_next = (CALC_LEN > 0) ? S_CALC : S_WRITE;
                S_CALC:  if (at_limit)  state_next = S_WRITE;
                default: if (at_limit)  state_next = bus.loop ? S_READ : S_IDLE;
            endcase
        end
    end

    // Counter restarts at every phase boundary, in IDLE and on abort.
    assign clr = bus.abort || (state == S_IDLE) || at_limit;
    assign inc = !clr;

    phase_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (clr),
        .inc        (inc),
        .limit      (limit),
        .count      (count),
        .count_next (count_next),
        .at_limit   (at_limit)
    );

    // Outputs are registered from the next state so nothing combinational reaches the gating latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            en_r  <= 1'b0;
            en_w  <= 1'b0;
            addr  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            en_r  <= (state_next == S_READ);
            en_w  <= (state_next == S_WRITE);
            addr  <= (state_next == S_READ || state_next == S_WRITE) ? count_next : '0;
            busy  <= (state_next != S_IDLE);
            done  <= (state_next == S_WRITE) && (count_next == WRITE_LIM);
        end
    end

    assign bus.en_r  = en_r;
    assign bus.en_w  = en_w;
    assign bus.addr  = addr;
    assign bus.phase = state;
    assign bus.busy  = busy;
    assign bus.done  = done;

endmodule

// File: tb/tb_clock_gating_ctrl.sv
// Self-checking bench: default-length batch sequences, a short-parameter
// vector table, and random stimulus against a batch-position model.
module tb_clock_gating_ctrl;
    import clock_gating_pkg::*;

    localparam int CR = 5, CC = 3, CWL = 4;
    localparam int CTOT = CR + CC + CWL;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fails = 0;

    clock_gating_ctrl_if #(.CNT_W(11)) ifa ();
    clock_gating_ctrl_if #(.CNT_W(3))  ifb ();
    clock_gating_ctrl_if #(.CNT_W(3))  ifc ();

    clock_gating_ctrl #(.READ_LEN(1024), .CALC_LEN(100), .WRITE_LEN(1024), .CNT_W(11))
        dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
    clock_gating_ctrl #(.READ_LEN(4), .CALC_LEN(0), .WRITE_LEN(3), .CNT_W(3))
        dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));
    clock_gating_ctrl #(.READ_LEN(CR), .CALC_LEN(CC), .WRITE_LEN(CWL), .CNT_W(3))
        dut_c (.clk(clk), .reset_n(reset_n), .bus(ifc));

    typedef struct {
        logic       start, loop, abort;
        logic [1:0] phase;
        logic [2:0] addr;
        logic       en_r, en_w, done, busy;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t v(input int s, l, a, ph, ad, er, ew, dn, bz);
        vec_t r;
        r.start = (s != 0); r.loop = (l != 0); r.abort = (a != 0);
        r.phase = 2'(ph);   r.addr = 3'(ad);
        r.en_r = (er != 0); r.en_w = (ew != 0); r.done = (dn != 0); r.busy = (bz != 0);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start_a();
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
    endtask

    // Advance DUT A until it is in phase p at the given addr (or CALC cycle count).
    task automatic run_until_a(input int p, input int target, output bit ok);
        int calc_seen;
        ok = 1'b0;
        calc_seen = 0;
        for (int i = 0; i < 2400 && !ok; i++) begin
            tick();
            if (ifa.phase == 2'(p)) begin
                if (p == 2) begin
                    calc_seen++;
                    if (calc_seen == target) ok = 1'b1;
                end else if (ifa.addr == 11'(target)) begin
                    ok = 1'b1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        assert (!(ifa.en_r && ifa.en_w) && !(ifb.en_r && ifb.en_w) && !(ifc.en_r && ifc.en_w))
        else begin
            n_fails++;
            $display("FAIL exclusivity: en_r and en_w both high at %0t", $time);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, saw_done, saw_busy, expect_r;
        int nr, nw, ng, first_w, done_at, bad_addr;
        int dones[$];
        bit m_act;
        int m_pos, m_ph, m_addr;
        logic [8:0] got, exp;
        bit rs, rl, ra;

        vecs[0]  = v(1,0,0, 1,0, 1,0,0,1);
        vecs[1]  = v(0,0,0, 1,1, 1,0,0,1);
        vecs[2]  = v(1,0,0, 1,2, 1,0,0,1);
        vecs[3]  = v(0,0,0, 1,3, 1,0,0,1);
        vecs[4]  = v(0,0,0, 3,0, 0,1,0,1);
        vecs[5]  = v(1,0,0, 3,1, 0,1,0,1);
        vecs[6]  = v(0,0,0, 3,2, 0,1,1,1);
        vecs[7]  = v(0,0,0, 0,0, 0,0,0,0);
        vecs[8]  = v(1,0,1, 0,0, 0,0,0,0);
        vecs[9]  = v(1,0,0, 1,0, 1,0,0,1);
        vecs[10] = v(0,0,1, 0,0, 0,0,0,0);
        vecs[11] = v(1,1,0, 1,0, 1,0,0,1);
        vecs[12] = v(0,1,0, 1,1, 1,0,0,1);
        vecs[13] = v(0,1,0, 1,2, 1,0,0,1);
        vecs[14] = v(0,1,0, 1,3, 1,0,0,1);
        vecs[15] = v(0,1,0, 3,0, 0,1,0,1);
        vecs[16] = v(0,1,0, 3,1, 0,1,0,1);
        vecs[17] = v(0,1,0, 3,2, 0,1,1,1);
        vecs[18] = v(0,1,0, 1,0, 1,0,0,1);
        vecs[19] = v(0,0,0, 1,1, 1,0,0,1);
        vecs[20] = v(0,0,1, 0,0, 0,0,0,0);

        {ifa.start, ifa.loop, ifa.abort} = 3'b000;
        {ifb.start, ifb.loop, ifb.abort} = 3'b000;
        {ifc.start, ifc.loop, ifc.abort} = 3'b000;

        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        tick();

        // Reset state
        check("rst en_r", ifa.en_r, 0);
        check("rst en_w", ifa.en_w, 0);
        check("rst addr", ifa.addr, 0);
        check("rst phase", ifa.phase, 0);
        check("rst busy", ifa.busy, 0);
        check("rst done", ifa.done, 0);

        // Single default batch
        nr = 0; nw = 0; ng = 0; first_w = 0; done_at = 0; bad_addr = 0;
        pulse_start_a();
        for (int c = 1; c <= 2150; c++) begin
            if (c > 1) tick();
            if (ifa.en_r) begin
                nr++;
                if (ifa.addr != 11'(c - 1)) bad_addr++;
            end
            if (ifa.en_w) begin
                nw++;
                if (first_w == 0) first_w = c;
                if (ifa.addr != 11'(c - 1125)) bad_addr++;
            end
            if (ifa.busy && !ifa.en_r && !ifa.en_w) begin
                ng++;
                if (ifa.addr != 0) bad_addr++;
            end
            if (ifa.done) done_at = c;
        end
        check("batch en_r cycles", nr, 1024);
        check("batch calc cycles", ng, 100);
        check("batch en_w cycles", nw, 1024);
        check("batch first en_w", first_w, 1125);
        check("batch done cycle", done_at, 2148);
        check("batch addr errors", bad_addr, 0);
        check("batch end busy", ifa.busy, 0);
        check("batch end phase", ifa.phase, 0);

        // Looping batches
        ifa.loop = 1'b1;
        pulse_start_a();
        expect_r = 1'b0;
        for (int c = 1; c <= 3 * 2148 + 20; c++) begin
            if (c > 1) tick();
            if (expect_r) begin
                check("loop en_r after done", ifa.en_r, 1);
                check("loop addr after done", ifa.addr, 0);
                expect_r = 1'b0;
            end
            if (ifa.done) begin
                dones.push_back(c);
                if (dones.size() == 3) ifa.loop = 1'b0;
                else expect_r = 1'b1;
            end
        end
        check("loop done count", dones.size(), 3);
        if (dones.size() == 3) begin
            check("loop first done", dones[0], 2148);
            check("loop spacing 1", dones[1] - dones[0], 2148);
            check("loop spacing 2", dones[2] - dones[1], 2148);
        end
        check("loop end phase", ifa.phase, 0);

        // Abort in READ, CALC, WRITE
        for (int p = 1; p <= 3; p++) begin
            pulse_start_a();
            run_until_a(p, (p == 2) ? 50 : 500, ok);
            check($sformatf("abort%0d reached", p), ok, 1);
            ifa.abort = 1'b1;
            tick();
            ifa.abort = 1'b0;
            check($sformatf("abort%0d phase", p), ifa.phase, 0);
            check($sformatf("abort%0d en_r", p), ifa.en_r, 0);
            check($sformatf("abort%0d en_w", p), ifa.en_w, 0);
            check($sformatf("abort%0d addr", p), ifa.addr, 0);
            check($sformatf("abort%0d busy", p), ifa.busy, 0);
            check($sformatf("abort%0d done", p), ifa.done, 0);
            saw_done = 1'b0; saw_busy = 1'b0;
            for (int i = 0; i < 2200; i++) begin
                tick();
                if (ifa.done) saw_done = 1'b1;
                if (ifa.busy) saw_busy = 1'b1;
            end
            check($sformatf("abort%0d later done", p), saw_done, 0);
            check($sformatf("abort%0d later busy", p), saw_busy, 0);
        end

        // Asynchronous reset during WRITE
        pulse_start_a();
        run_until_a(3, 300, ok);
        check("reset reached write", ok, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async rst en_r", ifa.en_r, 0);
        check("async rst en_w", ifa.en_w, 0);
        check("async rst addr", ifa.addr, 0);
        check("async rst phase", ifa.phase, 0);
        check("async rst busy", ifa.busy, 0);
        check("async rst done", ifa.done, 0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        saw_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ifa.busy || ifa.phase != 0) saw_busy = 1'b1;
        end
        check("post reset stays idle", saw_busy, 0);
        pulse_start_a();
        check("post reset start en_r", ifa.en_r, 1);
        check("post reset start addr", ifa.addr, 0);
        ifa.abort = 1'b1;
        tick();
        ifa.abort = 1'b0;

        // Short-parameter vector table
        for (int i = 0; i < 21; i++) begin
            ifb.start = vecs[i].start;
            ifb.loop  = vecs[i].loop;
            ifb.abort = vecs[i].abort;
            tick();
            got = {ifb.phase, ifb.addr, ifb.en_r, ifb.en_w, ifb.done, ifb.busy};
            exp = {vecs[i].phase, vecs[i].addr, vecs[i].en_r, vecs[i].en_w, vecs[i].done, vecs[i].busy};
            check($sformatf("vec[%0d] {phase,addr,en_r,en_w,done,busy}", i), got, exp);
        end
        {ifb.start, ifb.loop, ifb.abort} = 3'b000;

        // Random stimulus vs batch-position model
        m_act = 1'b0;
        m_pos = 0;
        for (int c = 0; c < 30000 && n_fails < 20; c++) begin
            rs = ($urandom_range(3) == 0);
            ra = ($urandom_range(31) == 0);
            rl = $urandom_range(1) != 0;
            ifc.start = rs; ifc.loop = rl; ifc.abort = ra;
            tick();
            if (ra) m_act = 1'b0;
            else if (!m_act) begin
                if (rs) begin m_act = 1'b1; m_pos = 0; end
            end else if (m_pos == CTOT - 1) begin
                if (rl) m_pos = 0; else m_act = 1'b0;
            end else m_pos++;

            if (!m_act) begin
                exp = '0;
            end else begin
                if (m_pos < CR) begin m_ph = 1; m_addr = m_pos; end
                else if (m_pos < CR + CC) begin m_ph = 2; m_addr = 0; end
                else begin m_ph = 3; m_addr = m_pos - CR - CC; end
                exp = {2'(m_ph), 3'(m_addr), m_ph == 1, m_ph == 3, m_pos == CTOT - 1, 1'b1};
            end
            got = {ifc.phase, ifc.addr, ifc.en_r, ifc.en_w, ifc.done, ifc.busy};
            check($sformatf("rand cycle %0d {phase,addr,en_r,en_w,done,busy}", c), got, exp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
